// File: rtl/ir_cmd_ctrl.sv
// rtl/ir_cmd_ctrl.sv - IR frame filter, press/repeat FSM and 4-entry event FIFO
// Optional repeat events are enabled by defining IR_CMD_REPEAT_EN.
module ir_cmd_ctrl #(
    parameter logic [4:0] ADDR_MASK       = 5'h1F,
    parameter logic [4:0] ADDR_MATCH      = 5'h01,
    parameter int         CONFIRM_COUNT   = 2,
    parameter int         REPEAT_DIV      = 4,
    parameter int         RELEASE_TIMEOUT = 4000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] frame_data,
    input  logic        frame_rdy,
    output logic [6:0]  cmd_code,
    output logic [4:0]  cmd_addr,
    output logic        cmd_repeat,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        key_held,
    output logic        overflow,
    input  logic        ovf_clr
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CONFIRM = 2'd1;
    localparam logic [1:0] S_HELD    = 2'd2;

    localparam int          TW      = $clog2(RELEASE_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(RELEASE_TIMEOUT - 1);
    localparam logic [2:0]  CC      = 3'(CONFIRM_COUNT);
    localparam logic [3:0]  RD      = 4'(REPEAT_DIV);

    logic [1:0]    state, state_n;
    logic [11:0]   code_q, code_n;
    logic [2:0]    match_cnt, match_n;
    logic [3:0]    rep_cnt, rep_n;
    logic [TW-1:0] timer;
    logic          rdy_q;
    logic          new_frame, accept, same, timeout;
    logic          push, push_rep;

    assign new_frame = frame_rdy & ~rdy_q;
    assign accept    = new_frame &&
                       ((frame_data[11:7] & ADDR_MASK) == (ADDR_MATCH & ADDR_MASK));
    assign same      = (frame_data == code_q);
    // The timer reaches TO_LAST on the cycle before the RELEASE_TIMEOUT-th idle edge.
    assign timeout   = (state != S_IDLE) && (timer == TO_LAST);
    assign key_held  = (state == S_HELD);

    always_comb begin
        state_n  = state;
        code_n   = code_q;
        match_n  = match_cnt;
        rep_n    = rep_cnt;
        push     = 1'b0;
        push_rep = 1'b0;
        if (accept) begin
            if (state == S_IDLE || !same) begin
                code_n  = frame_data;
                match_n = 3'd1;
                rep_n   = 4'd0;
                if (CC == 3'd1) begin
                    state_n = S_HELD;
                    push    = 1'b1;
                end else begin
                    state_n = S_CONFIRM;
                end
            end else if (state == S_CONFIRM) begin
                match_n = match_cnt + 3'd1;
                if (match_n == CC) begin
                    push    = 1'b1;
                    rep_n   = 4'd0;
                    state_n = S_HELD;
                end
            end else begin
`ifdef IR_CMD_REPEAT_EN
                rep_n = rep_cnt + 4'd1;
                if (rep_n == RD) begin
                    push     = 1'b1;
                    push_rep = 1'b1;
                    rep_n    = 4'd0;
                end
`endif
            end
        end else if (timeout) begin
            state_n = S_IDLE;
            match_n = 3'd0;
            rep_n   = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            code_q    <= 12'd0;
            match_cnt <= 3'd0;
            rep_cnt   <= 4'd0;
            timer     <= '0;
            rdy_q     <= 1'b0;
        end else begin
            state     <= state_n;
            code_q    <= code_n;
            match_cnt <= match_n;
            rep_cnt   <= rep_n;
            rdy_q     <= frame_rdy;
            if (accept || timeout || state == S_IDLE)
                timer <= '0;
            else
                timer <= timer + 1'b1;
        end
    end

    logic [12:0] mem [4];
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  count;
    logic        full, pop, push_ok, drop;

    assign full    = (count == 3'd4);
    assign pop     = cmd_valid & cmd_ready;
    assign push_ok = push & (~full | pop);
    assign drop    = push & full & ~pop;

    assign cmd_valid  = (count != 3'd0);
    assign cmd_repeat = mem[rd_ptr][12];
    assign cmd_addr   = mem[rd_ptr][11:7];
    assign cmd_code   = mem[rd_ptr][6:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) mem[i] <= 13'd0;
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            count    <= 3'd0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= {push_rep, frame_data};
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 2'd1;
            case ({push_ok, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            if (drop)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ir_cmd_ctrl.sv
// tb/tb_ir_cmd_ctrl.sv - self-checking bench for ir_cmd_ctrl
module tb_ir_cmd_ctrl;
    localparam int RT = 16;
`ifdef IR_CMD_REPEAT_EN
    localparam int REP = 1;
`else
    localparam int REP = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, frame_rdy, cmd_ready, ovf_clr;
    logic [11:0] frame_data;
    logic [6:0]  cmd_code;
    logic [4:0]  cmd_addr;
    logic        cmd_repeat, cmd_valid, key_held, overflow;

    always #5 clk = ~clk;

    ir_cmd_ctrl #(.RELEASE_TIMEOUT(RT)) dut (
        .clk(clk), .rst_n(rst_n), .frame_data(frame_data), .frame_rdy(frame_rdy),
        .cmd_code(cmd_code), .cmd_addr(cmd_addr), .cmd_repeat(cmd_repeat),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .key_held(key_held),
        .overflow(overflow), .ovf_clr(ovf_clr)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [12:0] ev_q [$];

    // Logs each handshake once; inputs only change 1 time unit after the edge.
    always @(posedge clk) begin
        #2;
        if (rst_n && cmd_valid && cmd_ready)
            ev_q.push_back({cmd_repeat, cmd_addr, cmd_code});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [11:0] d);
        frame_data = d;
        frame_rdy  = 1'b1;
        step();
        frame_rdy  = 1'b0;
        step();
    endtask

    typedef struct {
        logic [11:0] frame;
        logic        held;
        int          ev_norep;
        int          ev_rep;
    } vec_t;

    vec_t        vecs [12];
    logic [12:0] exp_tab [$];
    int          base;

    initial begin
        vecs[0]  = '{12'h095, 1'b0, 0, 0};
        vecs[1]  = '{12'h095, 1'b1, 1, 1};
        vecs[2]  = '{12'h115, 1'b1, 1, 1};
        vecs[3]  = '{12'h095, 1'b1, 1, 1};
        vecs[4]  = '{12'h095, 1'b1, 1, 1};
        vecs[5]  = '{12'h095, 1'b1, 1, 1};
        vecs[6]  = '{12'h095, 1'b1, 1, 2};
        vecs[7]  = '{12'h0A0, 1'b0, 1, 2};
        vecs[8]  = '{12'h0A0, 1'b1, 2, 3};
        vecs[9]  = '{12'h095, 1'b0, 2, 3};
        vecs[10] = '{12'h0A0, 1'b0, 2, 3};
        vecs[11] = '{12'h0A0, 1'b1, 3, 4};
        exp_tab.push_back(13'h0095);
`ifdef IR_CMD_REPEAT_EN
        exp_tab.push_back(13'h1095);
`endif
        exp_tab.push_back(13'h00A0);
        exp_tab.push_back(13'h00A0);

        rst_n = 1'b0; frame_rdy = 1'b0; frame_data = 12'd0; cmd_ready = 1'b1; ovf_clr = 1'b0;
        repeat (3) step();
        check("rst_valid", 32'(cmd_valid), 0);
        check("rst_code", 32'(cmd_code), 0);
        check("rst_addr", 32'(cmd_addr), 0);
        check("rst_repeat", 32'(cmd_repeat), 0);
        check("rst_held", 32'(key_held), 0);
        check("rst_ovf", 32'(overflow), 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 12; i++) begin
            send_frame(vecs[i].frame);
            step();
            step();
            check($sformatf("tab%0d_held", i), 32'(key_held), 32'(vecs[i].held));
            check($sformatf("tab%0d_events", i), 32'(ev_q.size()),
                  32'(REP ? vecs[i].ev_rep : vecs[i].ev_norep));
        end
        for (int i = 0; i < exp_tab.size(); i++)
            check($sformatf("tab_event%0d", i), 32'(ev_q[i]), 32'(exp_tab[i]));

        repeat (RT + 2) step();
        check("idle_after_timeout", 32'(key_held), 0);
        base = ev_q.size();
        for (int i = 0; i < 3; i++) begin
            send_frame(12'h115);
            step();
        end
        check("filter_held", 32'(key_held), 0);
        check("filter_valid", 32'(cmd_valid), 0);
        check("filter_events", 32'(ev_q.size()), 32'(base));

        base = ev_q.size();
        for (int i = 0; i < 10; i++)
            send_frame(12'h0B3);
        check("ten_held", 32'(key_held), 1);
        repeat (RT - 2) step();
        check("timeout_minus1_held", 32'(key_held), 1);
        step();
        check("timeout_held", 32'(key_held), 0);
        check("ten_events", 32'(ev_q.size()), 32'(base + 1 + 2 * REP));
        check("ten_press", 32'(ev_q[base]), 32'h00B3);
`ifdef IR_CMD_REPEAT_EN
        check("ten_rep1", 32'(ev_q[base + 1]), 32'h10B3);
        check("ten_rep2", 32'(ev_q[base + 2]), 32'h10B3);
`endif
        send_frame(12'h0B3);
        check("repress_first", 32'(key_held), 0);
        send_frame(12'h0B3);
        check("repress_second", 32'(key_held), 1);
        step();
        check("repress_events", 32'(ev_q.size()), 32'(base + 2 + 2 * REP));
        check("repress_event", 32'(ev_q[ev_q.size() - 1]), 32'h00B3);

        cmd_ready = 1'b0;
        send_frame(12'h081);
        frame_data = 12'h081;
        frame_rdy  = 1'b1;
        check("latency_before", 32'(cmd_valid), 0);
        step();
        check("latency_after", 32'(cmd_valid), 1);
        frame_rdy = 1'b0;
        step();
        for (int k = 2; k <= 6; k++) begin
            send_frame(12'h080 | 12'(k));
            send_frame(12'h080 | 12'(k));
        end
        check("ovf_set", 32'(overflow), 1);
        check("ovf_head", 32'(cmd_code), 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("ovf_clear", 32'(overflow), 0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("drain%0d", k), 32'({cmd_repeat, cmd_addr, cmd_code}),
                  32'({1'b0, 5'd1, 7'(k + 1)}));
            cmd_ready = 1'b1;
            step();
            cmd_ready = 1'b0;
        end
        check("drain_empty", 32'(cmd_valid), 0);
        cmd_ready = 1'b1;
        step();
        step();
        check("pop_empty_valid", 32'(cmd_valid), 0);
        cmd_ready = 1'b0;

        send_frame(12'h090);
        send_frame(12'h090);
        send_frame(12'h091);
        check("pre_rst_valid", 32'(cmd_valid), 1);
        check("pre_rst_held", 32'(key_held), 0);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(cmd_valid), 0);
        check("arst_code", 32'(cmd_code), 0);
        check("arst_addr", 32'(cmd_addr), 0);
        check("arst_held", 32'(key_held), 0);
        check("arst_ovf", 32'(overflow), 0);
        frame_data = 12'h097;
        frame_rdy  = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        frame_rdy = 1'b0;
        step();
        send_frame(12'h097);
        check("rdy_at_release_held", 32'(key_held), 1);
        check("rdy_at_release_valid", 32'(cmd_valid), 1);
        check("rdy_at_release_code", 32'(cmd_code), 32'h17);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ir_cmd_ctrl.md
IR_CMD_CTRL -- requirements
Module: ir_cmd_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDR_MASK, 5'h1F, address bits compared by the filter (0 = accept any address).
- ADDR_MATCH, 5'h01, required address value under ADDR_MASK.
- CONFIRM_COUNT, 2, identical consecutive frames needed before a press event (range 1..7).
- REPEAT_DIV, 4, held-key frames per repeat event (range 1..15).
- RELEASE_TIMEOUT, 4000000, clk cycles without an accepted frame before the key counts as released.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- frame_data, in, 12, received frame: [6:0] command, [11:7] address.
- frame_rdy, in, 1, level; high while frame_data holds a complete frame.
- cmd_code, out, 7, command of the FIFO head event.
- cmd_addr, out, 5, address of the FIFO head event.
- cmd_repeat, out, 1, head event is a repeat (1) or a press (0).
- cmd_valid, out, 1, FIFO non-empty.
- cmd_ready, in, 1, consumer accepts the head event.
- key_held, out, 1, high while the FSM is in S_HELD.
- overflow, out, 1, sticky; an event was dropped because the FIFO was full.
- ovf_clr, in, 1, synchronous clear of overflow.

Function
REQ-003 A new frame SHALL be detected on a 0->1 transition of frame_rdy, using a registered copy; a level held high SHALL yield exactly one frame.
REQ-004 A frame SHALL be accepted only if (addr & ADDR_MASK) == (ADDR_MATCH & ADDR_MASK); rejected frames SHALL have no effect on FSM, counters or timer.
REQ-005 FSM states SHALL be S_IDLE, S_CONFIRM and S_HELD.
REQ-006 S_IDLE: an accepted frame SHALL store its {addr,cmd} and set match_cnt=1; the FSM SHALL enter S_HELD and push a press event if CONFIRM_COUNT==1, otherwise it SHALL enter S_CONFIRM.
REQ-007 S_CONFIRM: an identical frame SHALL increment match_cnt; on reaching CONFIRM_COUNT the FSM SHALL push a press event, clear rep_cnt and enter S_HELD. A different accepted frame SHALL replace the stored code and set match_cnt=1.
REQ-008 S_HELD: a different accepted frame SHALL be handled exactly as in S_IDLE (REQ-006); an identical frame SHALL be handled per REQ-016.
REQ-009 The gap timer SHALL clear on every accepted frame and count up in S_CONFIRM and S_HELD; at RELEASE_TIMEOUT the FSM SHALL enter S_IDLE with no event pushed. In S_IDLE the timer SHALL hold at 0.
REQ-010 If a timeout and an accepted frame coincide, the frame SHALL win.
REQ-011 Events SHALL go into a 4-entry FIFO of {repeat, addr[4:0], cmd[6:0]}. cmd_* outputs SHALL present the head entry, and the head SHALL be popped when cmd_valid && cmd_ready.
REQ-012 Latency: an event pushed on the edge where the frame is detected SHALL give cmd_valid=1 from the next cycle if the FIFO was empty.
REQ-013 A push into a full FIFO without a simultaneous pop SHALL be dropped and set overflow. A push and pop in the same cycle while full SHALL both succeed.
REQ-014 Pop while empty SHALL be ignored. FIFO pointers SHALL wrap modulo 4.
REQ-015 ovf_clr SHALL clear overflow next cycle unless a drop occurs in the same cycle, in which case set wins.

Reset
REQ-017 While rst_n=0 the block SHALL set: state S_IDLE, FIFO empty, cmd_valid=0, cmd_code=0, cmd_addr=0, cmd_repeat=0, key_held=0, overflow=0, all counters and the timer 0, and the registered frame_rdy to 0.
REQ-018 Deassertion of reset SHALL take effect on the next clock edge. If frame_rdy is already high at that edge, it SHALL count as a new frame.

Configuration
REQ-016 Macro IR_CMD_REPEAT_EN defined: each identical frame in S_HELD SHALL increment rep_cnt, and when rep_cnt reaches REPEAT_DIV the block SHALL push a repeat event and clear rep_cnt. Macro undefined: identical frames in S_HELD SHALL only clear the timer, and no repeat events SHALL ever be produced.

Verification
REQ-019 Two frames 12'h095 (addr 1, cmd 0x15), cmd_ready=1 -> exactly one press event {0,1,0x15}, and key_held=1 after the second frame.
REQ-020 Frames with addr 2, default filter -> cmd_valid stays 0 and the FSM stays in S_IDLE.
REQ-021 Ten identical frames with IR_CMD_REPEAT_EN defined -> 1 press event then 2 repeat events. Same stimulus with the macro undefined -> 1 press event only.
REQ-022 Press, then no frames for RELEASE_TIMEOUT cycles -> key_held falls exactly at the timeout. Same code again -> new press after CONFIRM_COUNT frames.
REQ-023 cmd_ready=0, six distinct codes confirmed -> 4 queued events, overflow=1. Pulse ovf_clr -> overflow=0. Drain -> the first four events come out in order.
REQ-024 rst_n pulsed low mid-S_CONFIRM with FIFO non-empty -> all outputs return to reset values asynchronously.
